sht40_frame_checker: RTL and testbench
======================================

// Module: sht40_frame_checker
// PURPOSE
// - Downstream consumer of the I2C master's receive path. It tracks each byte the master
//   completes in its receive state and assembles the SHT40 6-byte reply: T_msb T_lsb T_crc H_msb H_lsb H_crc.
// - Checks each word with CRC-8 and publishes temperature and humidity words.
// - Drives the CRC_Error input of the master, which aborts to the end state on a bad CRC.
// PARAMETERS
// - CRC_POLY   8'h31  CRC-8 polynomial x^8+x^5+x^4+1
// - CRC_INIT   8'hFF  CRC seed, reloaded at the start of every word
// - CRC_CYCLES 8      clocks per bit-serial CRC update (one bit per clk)
// PORTS
// - clk              in   1   system clock
// - rst_n            in   1   asynchronous active-low reset
// - Master_State_Out in   3   master state (3'b011 receive, 3'b110 end, 3'b000 processor)
// - Bytes_Received   in   4   master's running byte count; any change means a new byte is complete
// - Data_Received    in   8   last byte received by the master; valid on the cycle the count changes
// - CRC_Error        out  1   1-cycle pulse on CRC mismatch or overrun
// - Temp_Raw         out  16  last good temperature word
// - Hum_Raw          out  16  last good humidity word
// - Sample_Valid     out  1   1-cycle pulse when both words have passed CRC
// - Overrun          out  1   sticky; a byte arrived while the CRC engine was busy
// - Busy             out  1   high in COLLECT with a CRC update in progress
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
// - Reset values: all outputs 0, state IDLE, byte index 0, crc=CRC_INIT.
//   The count register is loaded from Bytes_Received on the first clock after reset.
// - Byte strobe: registered copy of Bytes_Received differs from the live value.
//   - Any change counts, including the 4'hF->4'h0 wrap.
//   - The strobe also latches Data_Received.
// - IDLE:
//   - Go to COLLECT when Master_State_Out==3'b011.
//   - On entry: index=0, crc=CRC_INIT, Overrun=0.
//   - Strobes in IDLE are tracked but ignored.
// - COLLECT, data bytes (index 0,1,3,4):
//   - Stored to word bits [15:8] or [7:0].
//   - Fed MSB-first into the CRC engine: CRC_CYCLES clocks, Busy high during the update.
// - COLLECT, CRC bytes (index 2,5), on the cycle after the strobe (N+1):
//   - Compare the byte with crc.
//   - Match: reload crc=CRC_INIT and continue.
//   - Mismatch: CRC_Error=1 at N+1 only; go to WAIT_END; outputs keep their old values.
// - Index 5 match, at N+1:
//   - Temp_Raw and Hum_Raw update.
//   - Sample_Valid=1 for that one cycle.
//   - Go to WAIT_END.
// - Overrun: a strobe while Busy discards that byte and sets Overrun=1 (sticky).
//   It also pulses CRC_Error on the next cycle and goes to WAIT_END.
// - WAIT_END: go to IDLE when Master_State_Out is 3'b110 or 3'b000. Strobes are ignored.
// - Master leaves receive mid-frame (state 3'b110/3'b000 in COLLECT):
//   - Partial frame is discarded.
//   - Go to IDLE with no pulse.
//   - Temp_Raw and Hum_Raw are unchanged.
// - Strobe on the same cycle as the leave-receive condition: the abort wins and the byte is dropped.
// - Reset mid-frame: all state clears immediately; the partial frame is lost.
// CONFIGURATION
// - SHT40_CONVERT_EN defined:
//   - Adds outputs Temp_Centi (16, signed) and Hum_Centi (16, unsigned).
//   - Both update in the same cycle as Temp_Raw/Hum_Raw.
//   - Temp_Centi = ((17500*S_T)>>16) - 4500, in 0.01 degC.
//   - Hum_Centi = ((12500*S_H)>>16) - 600, in 0.01 %RH, clamped to 0..10000.
//   - Products use a 31-bit intermediate.
// - SHT40_CONVERT_EN undefined: these outputs and their multipliers do not exist; all other behaviour is identical.
// TESTING
// - Receive entry, bytes BE EF 92 BE EF 92:
//   -> Temp_Raw=16'hBEEF, Hum_Raw=16'hBEEF.
//   -> Sample_Valid 1 cycle after the 6th strobe; CRC_Error never set.
// - Bytes BE EF 93:
//   -> CRC_Error pulse at strobe+1, single cycle.
//   -> No Sample_Valid; outputs hold prior values; bytes 4-6 are ignored until 3'b110.
// - SHT40_CONVERT_EN with frame BE EF 92 BE EF 92:
//   -> Temp_Centi=8552, Hum_Centi=8722.
// - SHT40_CONVERT_EN, humidity words 00 00 81 and FF FF AC:
//   -> Hum_Centi=0 and 10000 respectively (clamp).
// - Two strobes 3 clk apart:
//   -> Overrun=1, CRC_Error pulse, second byte dropped.
// - Abort cases:
//   -> rst_n low after byte 3: all outputs 0, state IDLE.
//   -> Master_State_Out=3'b110 after byte 4: state IDLE, no pulse.
//   -> Bytes_Received 4'hF->4'h0: counted as a strobe.

Source files
------------

// File: rtl/sht40_rx_if.sv
// Receive-side link between the I2C master and the SHT40 frame checker.
interface sht40_rx_if;
    logic [2:0] Master_State_Out;
    logic [3:0] Bytes_Received;
    logic [7:0] Data_Received;
    logic       CRC_Error;

    modport master (
        output Master_State_Out,
        output Bytes_Received,
        output Data_Received,
        input  CRC_Error
    );

    modport slave (
        input  Master_State_Out,
        input  Bytes_Received,
        input  Data_Received,
        output CRC_Error
    );
endinterface

// File: rtl/sht40_frame_checker.sv
// Assembles and CRC-checks the 6-byte SHT40 reply seen on the master's receive path.
// Optional SHT40_CONVERT_EN adds centi-unit temperature/humidity conversion outputs.
module sht40_frame_checker #(
    parameter logic [7:0]  CRC_POLY   = 8'h31,
    parameter logic [7:0]  CRC_INIT   = 8'hFF,
    parameter int unsigned CRC_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    sht40_rx_if.slave   rx,
    output logic [15:0] Temp_Raw,
    output logic [15:0] Hum_Raw,
    output logic        Sample_Valid,
    output logic        Overrun,
    output logic        Busy
`ifdef SHT40_CONVERT_EN
  , output logic signed [15:0] Temp_Centi,
    output logic [15:0]        Hum_Centi
`endif
);

    localparam logic [2:0] MS_RX   = 3'b011;
    localparam logic [2:0] MS_END  = 3'b110;
    localparam logic [2:0] MS_PROC = 3'b000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        WAIT_END = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        cnt_vld_q, cnt_vld_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  crc_q, crc_d;
    logic [7:0]  sh_q, sh_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] t_q, t_d;
    logic [15:0] h_q, h_d;
    logic [15:0] temp_raw_d, hum_raw_d;
    logic        crc_error_q, crc_error_d;
    logic        sample_valid_d, overrun_d, busy_d;
    logic        strobe_c;
    logic        leave_rx_c;

    assign strobe_c   = cnt_vld_q && (cnt_q != rx.Bytes_Received);
    assign leave_rx_c = (rx.Master_State_Out == MS_END) || (rx.Master_State_Out == MS_PROC);
    assign rx.CRC_Error = crc_error_q;

`ifdef SHT40_CONVERT_EN
    logic [30:0]        t_prod_c, h_prod_c;
    logic [14:0]        h_scaled_c;
    logic signed [15:0] temp_centi_c, temp_centi_d;
    logic [15:0]        hum_centi_c, hum_centi_d;

    // Scale from the frame words being published this cycle.
    assign t_prod_c   = 31'(17500) * 31'(t_q);
    assign h_prod_c   = 31'(12500) * 31'(h_q);
    assign h_scaled_c = h_prod_c[30:16];
    assign temp_centi_c = signed'(16'(t_prod_c[30:16]) - 16'd4500);

    always_comb begin
        hum_centi_c = 16'd0;
        if (h_scaled_c < 15'd600)
            hum_centi_c = 16'd0;
        else if (h_scaled_c > 15'd10600)
            hum_centi_c = 16'd10000;
        else
            hum_centi_c = 16'(h_scaled_c - 15'd600);
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = rx.Bytes_Received;
        cnt_vld_d      = 1'b1;
        idx_d          = idx_q;
        crc_d          = crc_q;
        sh_d           = sh_q;
        bit_cnt_d      = bit_cnt_q;
        t_d            = t_q;
        h_d            = h_q;
        temp_raw_d     = Temp_Raw;
        hum_raw_d      = Hum_Raw;
        crc_error_d    = 1'b0;
        sample_valid_d = 1'b0;
        overrun_d      = Overrun;
`ifdef SHT40_CONVERT_EN
        temp_centi_d   = Temp_Centi;
        hum_centi_d    = Hum_Centi;
`endif

        // Bit-serial CRC-8, MSB first, one bit per clock.
        if (bit_cnt_q != 4'd0) begin
            crc_d     = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ sh_q[7]) ? CRC_POLY : 8'h00);
            sh_d      = {sh_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (rx.Master_State_Out == MS_RX) begin
                    state_d   = COLLECT;
                    idx_d     = 3'd0;
                    crc_d     = CRC_INIT;
                    overrun_d = 1'b0;
                    bit_cnt_d = 4'd0;
                end
            end
            COLLECT: begin
                if (leave_rx_c) begin
                    state_d   = IDLE;
                    bit_cnt_d = 4'd0;
                end else if (strobe_c) begin
                    if (Busy) begin
                        overrun_d   = 1'b1;
                        crc_error_d = 1'b1;
                        state_d     = WAIT_END;
                        bit_cnt_d   = 4'd0;
                    end else if ((idx_q == 3'd2) || (idx_q == 3'd5)) begin
                        if (rx.Data_Received == crc_q) begin
                            crc_d = CRC_INIT;
                            if (idx_q == 3'd5) begin
                                temp_raw_d     = t_q;
                                hum_raw_d      = h_q;
                                sample_valid_d = 1'b1;
                                state_d        = WAIT_END;
`ifdef SHT40_CONVERT_EN
                                temp_centi_d   = temp_centi_c;
                                hum_centi_d    = hum_centi_c;
`endif
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end else begin
                            crc_error_d = 1'b1;
                            state_d     = WAIT_END;
                        end
                    end else begin
                        if (idx_q == 3'd0)      t_d[15:8] = rx.Data_Received;
                        else if (idx_q == 3'd1) t_d[7:0]  = rx.Data_Received;
                        else if (idx_q == 3'd3) h_d[15:8] = rx.Data_Received;
                        else                    h_d[7:0]  = rx.Data_Received;
                        sh_d      = rx.Data_Received;
                        bit_cnt_d = 4'(CRC_CYCLES);
                        idx_d     = idx_q + 3'd1;
                    end
                end
            end
            WAIT_END: begin
                if (leave_rx_c)
                    state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
            end
        endcase

        busy_d = (state_d == COLLECT) && (bit_cnt_d != 4'd0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            cnt_vld_q    <= 1'b0;
            idx_q        <= 3'd0;
            crc_q        <= CRC_INIT;
            sh_q         <= 8'd0;
            bit_cnt_q    <= 4'd0;
            t_q          <= 16'd0;
            h_q          <= 16'd0;
            Temp_Raw     <= 16'd0;
            Hum_Raw      <= 16'd0;
            crc_error_q  <= 1'b0;
            Sample_Valid <= 1'b0;
            Overrun      <= 1'b0;
            Busy         <= 1'b0;
`ifdef SHT40_CONVERT_EN
            Temp_Centi   <= 16'sd0;
            Hum_Centi    <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cnt_vld_q    <= cnt_vld_d;
            idx_q        <= idx_d;
            crc_q        <= crc_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            t_q          <= t_d;
            h_q          <= h_d;
            Temp_Raw     <= temp_raw_d;
            Hum_Raw      <= hum_raw_d;
            crc_error_q  <= crc_error_d;
            Sample_Valid <= sample_valid_d;
            Overrun      <= overrun_d;
            Busy         <= busy_d;
`ifdef SHT40_CONVERT_EN
            Temp_Centi   <= temp_centi_d;
            Hum_Centi    <= hum_centi_d;
`endif
        end
    end

endmodule

// File: tb/tb_sht40_frame_checker.sv
// Directed bench for sht40_frame_checker: good frames, CRC mismatch, overrun, aborts, count wrap.
module tb_sht40_frame_checker;

    logic        clk;
    logic        rst_n;
    logic [15:0] Temp_Raw;
    logic [15:0] Hum_Raw;
    logic        Sample_Valid;
    logic        Overrun;
    logic        Busy;
`ifdef SHT40_CONVERT_EN
    logic signed [15:0] Temp_Centi;
    logic [15:0]        Hum_Centi;
`endif

    sht40_rx_if rx ();

    sht40_frame_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .Temp_Raw     (Temp_Raw),
        .Hum_Raw      (Hum_Raw),
        .Sample_Valid (Sample_Valid),
        .Overrun      (Overrun),
        .Busy         (Busy)
`ifdef SHT40_CONVERT_EN
      , .Temp_Centi   (Temp_Centi),
        .Hum_Centi    (Hum_Centi)
`endif
    );

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         ce_cnt = 0;
    int         sv_cnt = 0;
    logic [3:0] cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (rx.CRC_Error === 1'b1) ce_cnt++;
        if (Sample_Valid === 1'b1) sv_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic strobe(input logic [7:0] b);
        cnt = cnt + 4'd1;
        rx.Bytes_Received = cnt;
        rx.Data_Received  = b;
        step();
    endtask

    task automatic send(input logic [7:0] b);
        strobe(b);
        repeat (8) step();
    endtask

    initial begin
        rst_n = 1'b0;
        cnt = 4'd0;
        rx.Master_State_Out = 3'b000;
        rx.Bytes_Received   = 4'd0;
        rx.Data_Received    = 8'd0;
        repeat (2) step();
        chk("rst_temp", Temp_Raw, 16'h0000);
        chk("rst_hum", Hum_Raw, 16'h0000);
        chk("rst_crc_err", 16'(rx.CRC_Error), 16'd0);
        chk("rst_sv", 16'(Sample_Valid), 16'd0);
        chk("rst_ovr", 16'(Overrun), 16'd0);
        chk("rst_busy", 16'(Busy), 16'd0);
        rst_n = 1'b1;
        step();
        step();

        // Good frame BE EF 92 BE EF 92
        rx.Master_State_Out = 3'b011;
        step();
        strobe(8'hBE);
        chk("busy_set", 16'(Busy), 16'd1);
        repeat (7) step();
        chk("busy_hold", 16'(Busy), 16'd1);
        step();
        chk("busy_clear", 16'(Busy), 16'd0);
        send(8'hEF); send(8'h92); send(8'hBE); send(8'hEF);
        strobe(8'h92);
        chk("a_sv", 16'(Sample_Valid), 16'd1);
        chk("a_temp", Temp_Raw, 16'hBEEF);
        chk("a_hum", Hum_Raw, 16'hBEEF);
`ifdef SHT40_CONVERT_EN
        chk("a_tcenti", 16'(Temp_Centi), 16'd8552);
        chk("a_hcenti", Hum_Centi, 16'd8722);
`endif
        step();
        chk("a_sv_one", 16'(Sample_Valid), 16'd0);
        chk("a_no_err", 16'(ce_cnt), 16'd0);
        rx.Master_State_Out = 3'b110; step();
        rx.Master_State_Out = 3'b000; step();

        // CRC mismatch BE EF 93, then trailing bytes ignored
        rx.Master_State_Out = 3'b011; step();
        send(8'hBE); send(8'hEF);
        strobe(8'h93);
        chk("m_err", 16'(rx.CRC_Error), 16'd1);
        chk("m_sv", 16'(Sample_Valid), 16'd0);
        step();
        chk("m_err_one", 16'(rx.CRC_Error), 16'd0);
        send(8'hBE); send(8'hEF); send(8'h92);
        chk("m_ce_cnt", 16'(ce_cnt), 16'd1);
        chk("m_sv_cnt", 16'(sv_cnt), 16'd1);
        chk("m_temp_hold", Temp_Raw, 16'hBEEF);
        rx.Master_State_Out = 3'b110; step();
        rx.Master_State_Out = 3'b000; step();

        // Overrun: two strobes 3 clk apart
        rx.Master_State_Out = 3'b011; step();
        strobe(8'hBE);
        step(); step();
        strobe(8'hEF);
        chk("o_ovr", 16'(Overrun), 16'd1);
        chk("o_err", 16'(rx.CRC_Error), 16'd1);
        step();
        chk("o_err_one", 16'(rx.CRC_Error), 16'd0);
        rx.Master_State_Out = 3'b000; step();
        chk("o_sticky", 16'(Overrun), 16'd1);
        rx.Master_State_Out = 3'b011; step();
        chk("o_cleared", 16'(Overrun), 16'd0);

        // Reset after byte 3
        send(8'hBE); send(8'hEF); send(8'h92);
        rst_n = 1'b0;
        #1;
        chk("r_temp", Temp_Raw, 16'h0000);
        chk("r_hum", Hum_Raw, 16'h0000);
        chk("r_ovr_busy", {15'd0, Overrun | Busy | Sample_Valid | rx.CRC_Error}, 16'd0);
        rx.Master_State_Out = 3'b000;
        step();
        rst_n = 1'b1;
        step(); step();

        // Leave receive after byte 4, then fresh frame 00 00 81 FF FF AC
        rx.Master_State_Out = 3'b011; step();
        send(8'hBE); send(8'hEF); send(8'h92); send(8'hBE);
        rx.Master_State_Out = 3'b110; step();
        chk("ab_err", 16'(rx.CRC_Error), 16'd0);
        chk("ab_temp", Temp_Raw, 16'h0000);
        step();
        chk("ab_ce_cnt", 16'(ce_cnt), 16'd2);
        rx.Master_State_Out = 3'b011; step();
        send(8'h00); send(8'h00); send(8'h81); send(8'hFF); send(8'hFF);
        strobe(8'hAC);
        chk("b_sv", 16'(Sample_Valid), 16'd1);
        chk("b_temp", Temp_Raw, 16'h0000);
        chk("b_hum", Hum_Raw, 16'hFFFF);
`ifdef SHT40_CONVERT_EN
        chk("b_tcenti", 16'(Temp_Centi), 16'hEE6C);
        chk("b_hcenti", Hum_Centi, 16'd10000);
`endif
        step();
        rx.Master_State_Out = 3'b000; step();

        // Count wrap F->0 on the first byte
        cnt = 4'hF;
        rx.Bytes_Received = cnt;
        step();
        rx.Master_State_Out = 3'b011; step();
        strobe(8'hBE);
        chk("w_busy", 16'(Busy), 16'd1);
        repeat (8) step();
        send(8'hEF); send(8'h92); send(8'h00); send(8'h00);
        strobe(8'h81);
        chk("w_sv", 16'(Sample_Valid), 16'd1);
        chk("w_temp", Temp_Raw, 16'hBEEF);
        chk("w_hum", Hum_Raw, 16'h0000);
`ifdef SHT40_CONVERT_EN
        chk("w_tcenti", 16'(Temp_Centi), 16'd8552);
        chk("w_hcenti", Hum_Centi, 16'd0);
`endif
        step();
        rx.Master_State_Out = 3'b000; step();
        chk("end_ce_cnt", 16'(ce_cnt), 16'd2);
        chk("end_sv_cnt", 16'(sv_cnt), 16'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
